switch_port_tx: RTL and testbench

- Ingress transmitter for one switch input port: the writer end of the 33-bit `{valid, data}` word stream consumed by the input side of `switch_4x4`.
- Accepts packet commands (destination, length) and payload words from a host over valid/ready handshakes.
- Emits one header word followed by the payload words, with a sequence number and an inter-packet gap.
- One instance per switch input port, sitting between the host/traffic source and the switch.

---
 rtl/switch_port_tx_if.sv | 25 ++
 rtl/switch_port_tx.sv | 95 +++++++++
 tb/tb_switch_port_tx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_port_tx_if.sv
// rtl/switch_port_tx_if.sv - host-side command/payload handshakes and switch-side word stream of one ingress port
interface switch_port_tx_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_dest;
  logic [5:0]  cmd_len;
  logic        data_valid;
  logic        data_ready;
  logic [31:0] data_word;
  logic        pause;
  logic [32:0] out_word;
  logic        busy;
  logic        cmd_err;
  logic [15:0] pkt_sent;

  modport master (
    output cmd_valid, cmd_dest, cmd_len, data_valid, data_word, pause,
    input  cmd_ready, data_ready, out_word, busy, cmd_err, pkt_sent
  );

  modport slave (
    input  cmd_valid, cmd_dest, cmd_len, data_valid, data_word, pause,
    output cmd_ready, data_ready, out_word, busy, cmd_err, pkt_sent
  );
endinterface

// File: rtl/switch_port_tx.sv
// rtl/switch_port_tx.sv - ingress transmitter: header + payload words with sequence number and inter-packet gap
module switch_port_tx #(
  parameter int SRC_PORT = 0,
  parameter int MAX_LEN  = 32,
  parameter int IPG      = 1
) (
  input logic            clk,
  input logic            rst,
  switch_port_tx_if.slave port
);

  localparam int              GW       = (IPG > 1) ? $clog2(IPG + 1) : 1;
  localparam logic [GW-1:0]   GAP_LOAD = GW'(IPG);
  localparam logic [6:0]      MAX_L    = 7'(MAX_LEN);
  localparam logic [1:0]      SRC      = 2'(SRC_PORT);

  typedef enum logic [1:0] {IDLE, PAYLOAD, GAP} state_t;

  // With no gap configured a finished packet returns straight to IDLE.
  localparam state_t END_STATE = (IPG == 0) ? IDLE : GAP;

  state_t        state;
  logic [5:0]    remaining;
  logic [7:0]    seq;
  logic [GW-1:0] gap_cnt;
  logic [15:0]   pkt_cnt;
  logic [32:0]   out_q;
  logic          err_q;
  logic          cmd_hs;
  logic          data_hs;
  logic          oversize;

  assign port.cmd_ready  = !rst && (state == IDLE) && !port.pause;
  assign port.data_ready = !rst && (state == PAYLOAD) && !port.pause;
  assign cmd_hs          = port.cmd_valid && port.cmd_ready;
  assign data_hs         = port.data_valid && port.data_ready;
  assign oversize        = {1'b0, port.cmd_len} > MAX_L;

  assign port.out_word = out_q;
  assign port.cmd_err  = err_q;
  assign port.pkt_sent = pkt_cnt;
  assign port.busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      seq       <= '0;
      gap_cnt   <= '0;
      pkt_cnt   <= '0;
      out_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      // Bubble unless a word is scheduled this cycle.
      out_q <= '0;
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_hs) begin
            if (oversize) begin
              err_q <= 1'b1;
            end else begin
              out_q     <= {1'b1, port.cmd_dest, SRC, port.cmd_len, seq, 14'd0};
              seq       <= seq + 8'd1;
              remaining <= port.cmd_len;
              gap_cnt   <= GAP_LOAD;
              if (port.cmd_len == 6'd0) begin
                pkt_cnt <= pkt_cnt + 16'd1;
                state   <= END_STATE;
              end else begin
                state <= PAYLOAD;
              end
            end
          end
        end
        PAYLOAD: begin
          if (data_hs) begin
            out_q     <= {1'b1, port.data_word};
            remaining <= remaining - 6'd1;
            if (remaining == 6'd1) begin
              pkt_cnt <= pkt_cnt + 16'd1;
              state   <= END_STATE;
            end
          end
        end
        GAP: begin
          if (gap_cnt <= GW'(1)) state <= IDLE;
          else gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_port_tx.sv
// tb/tb_switch_port_tx.sv - directed and randomized self-checking bench for switch_port_tx
module tb_switch_port_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  switch_port_tx_if ifa ();
  switch_port_tx_if ifb ();

  switch_port_tx #(.SRC_PORT(1), .MAX_LEN(32), .IPG(1)) dut_a (.clk(clk), .rst(rst_a), .port(ifa.slave));
  switch_port_tx #(.SRC_PORT(0), .MAX_LEN(32), .IPG(0)) dut_b (.clk(clk), .rst(rst_b), .port(ifb.slave));

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [1:0] dest;
    logic [5:0] len;
  } cmd_t;

  cmd_t        cq[$];
  logic [31:0] dq[$];
  logic [32:0] exp_q[$];
  int          n_over;
  int          n_legal;
  int          seq_m;
  int          err_seen;
  int          cyc;
  logic        hs_c;
  logic        hs_d;
  logic [31:0] w[4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] hdr(input int dest, input int src, input int len, input int seq);
    longint v;
    v = 64'h1_0000_0000 + (longint'(dest) << 30) + (longint'(src) << 28)
        + (longint'(len) << 22) + (longint'(seq % 256) << 14);
    return 33'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_all();
    ifa.cmd_valid = 1'b0; ifa.cmd_dest = '0; ifa.cmd_len = '0;
    ifa.data_valid = 1'b0; ifa.data_word = '0; ifa.pause = 1'b0;
    ifb.cmd_valid = 1'b0; ifb.cmd_dest = '0; ifb.cmd_len = '0;
    ifb.data_valid = 1'b0; ifb.data_word = '0; ifb.pause = 1'b0;
  endtask

  task automatic mon_a();
    if (ifa.out_word[32]) begin
      if (exp_q.size() == 0) chk("rnd_extra_word", 64'(ifa.out_word), 64'd0);
      else chk("rnd_word", 64'(ifa.out_word), 64'(exp_q.pop_front()));
    end
    if (ifa.cmd_err) err_seen++;
  endtask

  initial begin
    idle_all();
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_cmd_ready", 64'(ifa.cmd_ready), 64'd0);
    chk("rst_data_ready", 64'(ifa.data_ready), 64'd0);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    chk("reset_out", 64'(ifa.out_word), 64'd0);
    chk("reset_busy", 64'(ifa.busy), 64'd0);
    chk("reset_pkt", 64'(ifa.pkt_sent), 64'd0);
    chk("reset_err", 64'(ifa.cmd_err), 64'd0);
    chk("idle_cmd_ready", 64'(ifa.cmd_ready), 64'd1);
    chk("reset_out_b", 64'(ifb.out_word), 64'd0);

    // Basic packet: dest=2 len=3, SRC_PORT=1, IPG=1
    ifa.cmd_valid = 1'b1; ifa.cmd_dest = 2'd2; ifa.cmd_len = 6'd3;
    ifa.data_valid = 1'b1; ifa.data_word = 32'hA;
    step();
    ifa.cmd_valid = 1'b0;
    chk("t1_hdr", 64'(ifa.out_word), 64'h1_90C0_0000);
    chk("t1_busy", 64'(ifa.busy), 64'd1);
    step();
    chk("t1_d0", 64'(ifa.out_word), 64'h1_0000_000A);
    ifa.data_word = 32'hB;
    step();
    chk("t1_d1", 64'(ifa.out_word), 64'h1_0000_000B);
    ifa.data_word = 32'hC;
    step();
    chk("t1_d2", 64'(ifa.out_word), 64'h1_0000_000C);
    ifa.data_valid = 1'b0;
    step();
    chk("t1_gap", 64'(ifa.out_word), 64'd0);
    chk("t1_idle", 64'(ifa.busy), 64'd0);
    chk("t1_pkt", 64'(ifa.pkt_sent), 64'd1);

    // Oversized command: dropped, cmd_err single pulse, seq unchanged
    ifa.cmd_valid = 1'b1; ifa.cmd_dest = 2'd0; ifa.cmd_len = 6'd40;
    step();
    ifa.cmd_valid = 1'b0;
    chk("ovr_err", 64'(ifa.cmd_err), 64'd1);
    chk("ovr_out", 64'(ifa.out_word), 64'd0);
    chk("ovr_busy", 64'(ifa.busy), 64'd0);
    step();
    chk("ovr_err_end", 64'(ifa.cmd_err), 64'd0);
    ifa.cmd_valid = 1'b1; ifa.cmd_dest = 2'd1; ifa.cmd_len = 6'd0;
    step();
    ifa.cmd_valid = 1'b0;
    chk("ovr_next_hdr", 64'(ifa.out_word), 64'(hdr(1, 1, 0, 1)));
    step();
    chk("ovr_gap", 64'(ifa.out_word), 64'd0);
    chk("ovr_pkt", 64'(ifa.pkt_sent), 64'd2);

    // Pause for 3 cycles after the 2nd of 4 payload words
    for (int k = 0; k < 4; k++) w[k] = $urandom;
    ifa.cmd_valid = 1'b1; ifa.cmd_dest = 2'd3; ifa.cmd_len = 6'd4;
    ifa.data_valid = 1'b1; ifa.data_word = w[0];
    step();
    ifa.cmd_valid = 1'b0;
    chk("pz_hdr", 64'(ifa.out_word), 64'(hdr(3, 1, 4, 2)));
    step();
    chk("pz_w0", 64'(ifa.out_word), 64'({1'b1, w[0]}));
    ifa.data_word = w[1];
    step();
    chk("pz_w1", 64'(ifa.out_word), 64'({1'b1, w[1]}));
    ifa.data_word = w[2];
    ifa.pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("pz_ready", 64'(ifa.data_ready), 64'd0);
      step();
      chk("pz_bubble", 64'(ifa.out_word), 64'd0);
    end
    ifa.pause = 1'b0;
    step();
    chk("pz_w2", 64'(ifa.out_word), 64'({1'b1, w[2]}));
    ifa.data_word = w[3];
    step();
    chk("pz_w3", 64'(ifa.out_word), 64'({1'b1, w[3]}));
    ifa.data_valid = 1'b0;
    step();
    chk("pz_pkt", 64'(ifa.pkt_sent), 64'd3);

    // Asynchronous reset mid-payload
    ifa.cmd_valid = 1'b1; ifa.cmd_dest = 2'd0; ifa.cmd_len = 6'd5;
    ifa.data_valid = 1'b1; ifa.data_word = $urandom;
    step();
    ifa.cmd_valid = 1'b0;
    step();
    step();
    #2;
    rst_a = 1'b1;
    #1;
    chk("arst_out", 64'(ifa.out_word), 64'd0);
    chk("arst_busy", 64'(ifa.busy), 64'd0);
    chk("arst_pkt", 64'(ifa.pkt_sent), 64'd0);
    chk("arst_cmd_ready", 64'(ifa.cmd_ready), 64'd0);
    chk("arst_data_ready", 64'(ifa.data_ready), 64'd0);
    ifa.data_valid = 1'b0;
    @(negedge clk);
    rst_a = 1'b0;
    ifa.cmd_valid = 1'b1; ifa.cmd_dest = 2'd2; ifa.cmd_len = 6'd0;
    step();
    ifa.cmd_valid = 1'b0;
    chk("arst_hdr_seq0", 64'(ifa.out_word), 64'(hdr(2, 1, 0, 0)));
    step();

    // IPG=0: hdr, d0, hdr, d1 on consecutive cycles
    w[0] = $urandom; w[1] = $urandom;
    ifb.cmd_valid = 1'b1; ifb.cmd_dest = 2'd1; ifb.cmd_len = 6'd1;
    ifb.data_valid = 1'b1; ifb.data_word = w[0];
    step();
    chk("b2b_hdr0", 64'(ifb.out_word), 64'(hdr(1, 0, 1, 0)));
    ifb.cmd_dest = 2'd2;
    step();
    chk("b2b_d0", 64'(ifb.out_word), 64'({1'b1, w[0]}));
    ifb.data_word = w[1];
    step();
    ifb.cmd_valid = 1'b0;
    chk("b2b_hdr1", 64'(ifb.out_word), 64'(hdr(2, 0, 1, 1)));
    step();
    ifb.data_valid = 1'b0;
    chk("b2b_d1", 64'(ifb.out_word), 64'({1'b1, w[1]}));
    chk("b2b_pkt", 64'(ifb.pkt_sent), 64'd2);

    // 257 back-to-back zero-length packets: seq wraps on the 257th
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    ifb.cmd_valid = 1'b1; ifb.cmd_dest = 2'd0; ifb.cmd_len = 6'd0;
    for (int i = 0; i < 257; i++) begin
      step();
      if (i == 256) ifb.cmd_valid = 1'b0;
      chk("wrap_hdr", 64'(ifb.out_word), 64'(hdr(0, 0, 0, i)));
    end
    chk("wrap_pkt", 64'(ifb.pkt_sent), 64'd257);

    // Randomized traffic against an ordered-word reference
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    n_over = 0; n_legal = 0; seq_m = 0; err_seen = 0;
    for (int c = 0; c < 60; c++) begin
      cmd_t cm;
      int r;
      r = int'($urandom_range(0, 9));
      cm.dest = 2'($urandom_range(0, 3));
      cm.len  = (r == 0) ? 6'($urandom_range(33, 63)) : (r == 1) ? 6'd32 : (r == 2) ? 6'd33
              : 6'($urandom_range(0, 8));
      cq.push_back(cm);
      if (int'(cm.len) > 32) begin
        n_over++;
      end else begin
        exp_q.push_back(hdr(int'(cm.dest), 1, int'(cm.len), seq_m));
        seq_m++;
        n_legal++;
        for (int k = 0; k < int'(cm.len); k++) begin
          logic [31:0] d;
          d = $urandom;
          dq.push_back(d);
          exp_q.push_back({1'b1, d});
        end
      end
    end
    cyc = 0;
    while ((cq.size() > 0 || dq.size() > 0 || exp_q.size() > 0) && cyc < 20000) begin
      mon_a();
      ifa.cmd_valid = (cq.size() > 0) && ($urandom_range(0, 3) != 0);
      if (cq.size() > 0) begin
        ifa.cmd_dest = cq[0].dest;
        ifa.cmd_len  = cq[0].len;
      end
      ifa.data_valid = (dq.size() > 0) && ($urandom_range(0, 4) != 0);
      if (dq.size() > 0) ifa.data_word = dq[0];
      ifa.pause = ($urandom_range(0, 5) == 0);
      #1;
      hs_c = ifa.cmd_valid && ifa.cmd_ready;
      hs_d = ifa.data_valid && ifa.data_ready;
      @(posedge clk);
      if (hs_c) void'(cq.pop_front());
      if (hs_d) void'(dq.pop_front());
      @(negedge clk);
      cyc++;
    end
    idle_all();
    for (int k = 0; k < 4; k++) begin
      mon_a();
      step();
    end
    chk("rnd_timeout", 64'(cyc < 20000), 64'd1);
    chk("rnd_leftover", 64'(exp_q.size()), 64'd0);
    chk("rnd_err_pulses", 64'(err_seen), 64'(n_over));
    chk("rnd_pkt", 64'(ifa.pkt_sent), 64'(n_legal));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
